// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with exception/jump/branch redirect
// and the IF/ID pipeline register, including fetch address error detection.
module fetch_stage #(
   parameter logic [31:0] IM_BASE    = 32'h0000_3000,
   parameter int          IM_WORDS   = 1024,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_3F80
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        exc_req,
   input  logic        br_taken,
   input  logic [15:0] br_imm,
   input  logic        jump,
   input  logic [25:0] j_index,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   input  logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        fetch_exc_d
);

   localparam logic [31:0] IM_LAST = IM_BASE + 32'(IM_WORDS) * 32'd4 - 32'd4;

   logic [31:0] pc_d_plus4;
   logic [31:0] br_target;
   logic [31:0] jump_target;
   logic [31:0] pc_next;
   logic        fetch_err;

   assign pc_d_plus4  = pc_d + 32'd4;
   assign br_target   = pc_d_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
   assign jump_target = {pc_d_plus4[31:28], j_index, 2'b00};
   assign pc8_d       = pc_d + 32'd8;

   assign fetch_err = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_LAST);

   // Redirect sources are resolved in ID, so targets are relative to pc_d.
   always_comb begin
      // NOTE: default assignment first so every path drives pc_next; no latch.
      pc_next = pc_f + 32'd4;
      if (jr)
         pc_next = jr_addr;
      else if (jump)
         pc_next = jump_target;
      else if (br_taken)
         pc_next = br_target;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         pc_f        <= IM_BASE;
         instr_d     <= 32'h0;
         pc_d        <= 32'h0;
         fetch_exc_d <= 1'b0;
      end else if (exc_req) begin
         pc_f        <= EXC_VECTOR;
         instr_d     <= 32'h0;
         pc_d        <= 32'h0;
         fetch_exc_d <= 1'b0;
      end else if (!stall) begin
         pc_f        <= pc_next;
         // A bad fetch address turns the slot into a nop tagged with AdEL.
         instr_d     <= fetch_err ? 32'h0 : instr_f;
         pc_d        <= pc_f;
         fetch_exc_d <= fetch_err;
      end
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter IM_BASE, default 32'h00003000, lowest fetchable byte address and reset PC.
REQ-002 Parameter IM_WORDS, default 1024, instruction memory depth in words; legal PC range is IM_BASE .. IM_BASE+4*IM_WORDS-4.
REQ-003 Parameter EXC_VECTOR, default 32'h00003F80, exception handler entry PC; SHALL lie inside the legal range.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-007 exc_req  input  1  exception/flush request; redirects to EXC_VECTOR.
REQ-008 br_taken  input  1  conditional branch in ID resolved taken.
REQ-009 br_imm  input  16  branch offset field of the ID instruction.
REQ-010 jump  input  1  j/jal in ID.
REQ-011 j_index  input  26  instr_index field of the ID instruction.
REQ-012 jr  input  1  jr/jalr in ID.
REQ-013 jr_addr  input  32  forwarded register target for jr/jalr.
REQ-014 instr_f  input  32  instruction word returned combinationally by the instruction memory for pc_f.
REQ-015 pc_f  output  32  current fetch PC, drives instruction memory address.
REQ-016 instr_d  output  32  IF/ID instruction register.
REQ-017 pc_d  output  32  IF/ID PC register.
REQ-018 pc8_d  output  32  pc_d+8, link value for jal/jalr.
REQ-019 fetch_exc_d  output  1  registered fetch address error (AdEL) for the ID instruction.

Function
REQ-020 PC register next-value priority SHALL be: reset > exc_req > stall > jr > jump > br_taken > pc_f+4.
REQ-021 jr SHALL load jr_addr unmodified (no alignment masking).
REQ-022 jump SHALL load {pc_d[31:28]+carry of pc_d+4, j_index, 2'b00}, i.e. {(pc_d+4)[31:28], j_index, 2'b00}.
REQ-023 br_taken SHALL load pc_d + 4 + (sign-extended br_imm << 2), 32-bit wrap-around arithmetic.
REQ-024 Redirects SHALL take effect at the next rising edge (one-cycle latency); the instruction fetched in the redirect cycle (delay slot) SHALL enter ID normally, never flushed by a branch/jump.
REQ-025 While stall=1 and exc_req=0, pc_f, instr_d, pc_d, fetch_exc_d SHALL hold; redirect inputs SHALL be ignored.
REQ-026 Without stall/exc/reset, IF/ID SHALL capture instr_f, pc_f and the fetch-error flag each cycle.
REQ-027 Fetch error SHALL be pc_f[1:0]!=0, pc_f<IM_BASE, or pc_f>IM_BASE+4*IM_WORDS-4.
REQ-028 On fetch error, IF/ID SHALL capture instr_d=32'h0 (nop), pc_d=pc_f, fetch_exc_d=1; the PC continues to pc_f+4 unless redirected.
REQ-029 exc_req=1 SHALL load pc_f=EXC_VECTOR and clear IF/ID to instr_d=0, pc_d=0, fetch_exc_d=0, overriding stall and all redirects.
REQ-030 pc8_d SHALL be combinational pc_d+8 at all times.
REQ-031 Block SHALL contain no combinational path from instr_f to any output.

Reset
REQ-032 With reset=1 at a rising edge: pc_f=IM_BASE, instr_d=0, pc_d=0, fetch_exc_d=0, regardless of every other input.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL discard pending state; first fetch after release is IM_BASE.

Verification
REQ-034 Reset held 2 cycles then released -> pc_f=0x3000 during reset; one cycle after release pc_f=0x3004, instr_d=word at 0x3000, pc_d=0x3000, pc8_d=0x3008.
REQ-035 pc_d=0x3010, br_taken=1, br_imm=0xFFFC -> next pc_f=0x3004; delay-slot word from 0x3014 appears in instr_d with pc_d=0x3014.
REQ-036 stall=1 for 3 cycles with br_taken=1 and jump=1 asserted -> pc_f, instr_d, pc_d unchanged all 3 cycles; after release, sequential fetch resumes.
REQ-037 jr=1, jr_addr=0x3002 -> pc_f=0x3002; next edge fetch_exc_d=1, instr_d=0, pc_d=0x3002; jr_addr=0x5000 likewise flags error.
REQ-038 exc_req=1 together with stall=1 and jr=1 -> next pc_f=0x3F80, instr_d=0, pc_d=0, fetch_exc_d=0.
REQ-039 jump=1, j_index=0x0000C40, pc_d=0x3020 -> next pc_f=0x00003100.
